// File: rtl/router_output_arbiter_if.sv
// Handshake bundle between the router input ports and one output arbiter.
//   master : flit sources plus downstream ready (the router fabric / bench side)
//   slave  : the arbiter itself
// Signals:
//   data_in_bus  - concatenated candidate flits, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in_bus - per-input flit valid
//   ready_in_bus - per-input accept, one-hot or zero
//   data_out     - registered output flit
//   valid_out    - output flit valid
//   ready_out    - downstream accept
//   grant        - one-hot owner of the output, zero when idle
//   pkt_err      - sticky malformed-packet flag
interface router_output_arbiter_if #(
  parameter int unsigned INPUTS     = 3,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [INPUTS*DATA_WIDTH-1:0] data_in_bus;
  logic [INPUTS-1:0]            valid_in_bus;
  logic [INPUTS-1:0]            ready_in_bus;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         valid_out;
  logic                         ready_out;
  logic [INPUTS-1:0]            grant;
  logic                         pkt_err;

  modport master (
    output data_in_bus, valid_in_bus, ready_out,
    input  ready_in_bus, data_out, valid_out, grant, pkt_err
  );

  modport slave (
    input  data_in_bus, valid_in_bus, ready_out,
    output ready_in_bus, data_out, valid_out, grant, pkt_err
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Per-output-port switch allocator for the mesh router.
// Round-robin arbitration among INPUTS input ports with wormhole locking: the winner of a
// HEAD flit owns the output until its TAIL passes (or the packet hits FlitPerPacket flits).
// The output goes through a one-entry registered stage with valid/ready handshake.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - router_output_arbiter_if slave modport (flit inputs, output link, grant, pkt_err)
// Flit type in the top TYPE_WIDTH bits: 01 HEAD, 10 BODY, 11 TAIL, 00 SINGLE.
module router_output_arbiter #(
  parameter int unsigned INPUTS        = 3,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned TYPE_WIDTH    = 2,
  parameter int unsigned FlitPerPacket = 16
) (
  input logic                    clk,
  input logic                    rst,
  router_output_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int unsigned CntW = $clog2(FlitPerPacket + 1);

  localparam logic [TYPE_WIDTH-1:0] TypeSingle = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] TypeHead   = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TypeTail   = TYPE_WIDTH'(3);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       rr_q;
  logic [IdxW-1:0]       owner_q;
  logic [CntW-1:0]       cnt_q;
  logic [INPUTS-1:0]     grant_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_out_q;
  logic                  pkt_err_q;

  logic [TYPE_WIDTH-1:0] flit_type [INPUTS];
  logic [INPUTS-1:0]     cand;
  logic                  can_load;
  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic                  disc_found;
  logic [IdxW-1:0]       disc_idx;
  logic [IdxW-1:0]       sel_idx;
  logic [TYPE_WIDTH-1:0] sel_type;
  logic [DATA_WIDTH-1:0] sel_flit;
  logic [INPUTS-1:0]     ready;
  logic                  discard;
  logic                  xfer;
  logic                  load;
  int unsigned           scan_idx;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    if (32'(i) >= INPUTS - 1) begin
      return '0;
    end
    return i + IdxW'(1);
  endfunction

  // Per-input flit type and "can start a packet" candidates.
  always_comb begin
    for (int unsigned i = 0; i < INPUTS; i++) begin
      flit_type[i] = bus.data_in_bus[i*DATA_WIDTH + DATA_WIDTH - 1 -: TYPE_WIDTH];
      cand[i]      = bus.valid_in_bus[i] &&
                     (flit_type[i] == TypeHead || flit_type[i] == TypeSingle);
    end
  end

  always_comb begin
    can_load   = !valid_out_q || bus.ready_out;
    win_found  = 1'b0;
    win_idx    = '0;
    disc_found = 1'b0;
    disc_idx   = '0;
    scan_idx   = 0;

    // Round-robin scan starting at rr_q, wrapping modulo INPUTS.
    for (int unsigned k = 0; k < INPUTS; k++) begin
      scan_idx = 32'(rr_q) + k;
      if (scan_idx >= INPUTS) begin
        scan_idx = scan_idx - INPUTS;
      end
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(scan_idx);
      end
    end

    // Stray BODY/TAIL with no packet to belong to: lowest index gets flushed.
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (!disc_found && bus.valid_in_bus[i]) begin
        disc_found = 1'b1;
        disc_idx   = IdxW'(i);
      end
    end

    ready   = '0;
    discard = 1'b0;
    sel_idx = owner_q;
    if (!rst) begin
      if (state_q == StLocked) begin
        ready[owner_q] = can_load;
      end else if (win_found) begin
        ready[win_idx] = can_load;
        sel_idx        = win_idx;
      end else if (disc_found) begin
        // Gated by can_load so a stalled output shows no ready at all.
        ready[disc_idx] = can_load;
        sel_idx         = disc_idx;
        discard         = 1'b1;
      end
    end

    sel_type = flit_type[sel_idx];
    sel_flit = bus.data_in_bus[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    xfer     = |(ready & bus.valid_in_bus);
    load     = xfer && !discard;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      if (load) begin
        data_out_q  <= sel_flit;
        valid_out_q <= 1'b1;
      end else if (valid_out_q && bus.ready_out) begin
        valid_out_q <= 1'b0;
      end

      if (xfer && discard) begin
        pkt_err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (load) begin
            if (sel_type == TypeHead) begin
              state_q <= StLocked;
              owner_q <= sel_idx;
              grant_q <= INPUTS'(1) << sel_idx;
              cnt_q   <= CntW'(1);
            end else begin
              // SINGLE: whole packet done in one flit, rotate past the winner.
              rr_q <= next_idx(sel_idx);
            end
          end
        end
        StLocked: begin
          if (load) begin
            if (sel_type == TypeTail || cnt_q >= CntW'(FlitPerPacket - 1)) begin
              state_q <= StIdle;
              grant_q <= '0;
              rr_q    <= next_idx(owner_q);
              cnt_q   <= '0;
              // Reaching the length limit without a tail is a forced release.
              if (sel_type != TypeTail) begin
                pkt_err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
              if (sel_type == TypeHead || sel_type == TypeSingle) begin
                pkt_err_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.ready_in_bus = ready;
  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.grant        = grant_q;
  assign bus.pkt_err      = pkt_err_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: per-input flit source queues, an output
// collector, and hand-computed expected streams / per-cycle values.
module tb_router_output_arbiter;

  localparam int unsigned INPUTS     = 3;
  localparam int unsigned DATA_WIDTH = 64;
  localparam logic [1:0]  TH = 2'b01;
  localparam logic [1:0]  TB = 2'b10;
  localparam logic [1:0]  TT = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_output_arbiter_if #(.INPUTS(INPUTS), .DATA_WIDTH(DATA_WIDTH)) bus ();

  router_output_arbiter #(
    .INPUTS       (INPUTS),
    .DATA_WIDTH   (DATA_WIDTH),
    .TYPE_WIDTH   (2),
    .FlitPerPacket(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [63:0]       src_q [INPUTS][$];
  logic [63:0]       out_q [$];
  logic [63:0]       exp_q [$];
  logic [INPUTS-1:0] last_rdy;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] flit(input logic [1:0] t, input int unsigned src,
                                       input int unsigned seq);
    return {t, 30'd0, 16'(src), 16'(seq)};
  endfunction

  // One packet: HEAD, nbody BODY flits, optional TAIL.
  task automatic push_pkt(input int unsigned port, input int unsigned id,
                          input int unsigned nbody, input bit tail);
    src_q[port].push_back(flit(TH, port, id * 32));
    for (int unsigned k = 1; k <= nbody; k++) src_q[port].push_back(flit(TB, port, id * 32 + k));
    if (tail) src_q[port].push_back(flit(TT, port, id * 32 + nbody + 1));
  endtask

  task automatic expect_pkt(input int unsigned port, input int unsigned id,
                            input int unsigned nbody, input bit tail);
    exp_q.push_back(flit(TH, port, id * 32));
    for (int unsigned k = 1; k <= nbody; k++) exp_q.push_back(flit(TB, port, id * 32 + k));
    if (tail) exp_q.push_back(flit(TT, port, id * 32 + nbody + 1));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < INPUTS; i++) begin
      if (src_q[i].size() > 0) begin
        bus.valid_in_bus[i] = 1'b1;
        bus.data_in_bus[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0];
      end else begin
        bus.valid_in_bus[i] = 1'b0;
        bus.data_in_bus[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  endtask

  // Starts at posedge+1: drive, sample handshakes, clock, then retire what was accepted.
  task automatic cycle();
    logic [INPUTS-1:0] v;
    logic              vo;
    logic              ro;
    logic [63:0]       d;
    drive_inputs();
    #1;
    v        = bus.valid_in_bus;
    last_rdy = bus.ready_in_bus;
    vo       = bus.valid_out;
    ro       = bus.ready_out;
    d        = bus.data_out;
    @(posedge clk);
    #1;
    for (int i = 0; i < INPUTS; i++) begin
      if (v[i] && last_rdy[i]) void'(src_q[i].pop_front());
    end
    if (vo && ro) out_q.push_back(d);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.ready_out = 1'b1;
    drive_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("rst_data_out", bus.data_out, 64'd0);
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_pkt_err", 64'(bus.pkt_err), 64'd0);
    check("rst_ready_in", 64'(bus.ready_in_bus), 64'd0);
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag);
    check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, (i < out_q.size()) ? out_q[i] : {64{1'bx}}, exp_q[i]);
    end
    out_q.delete();
    exp_q.delete();
  endtask

  logic [INPUTS-1:0] t4_rdy [5];

  initial begin
    bus.valid_in_bus = '0;
    bus.data_in_bus  = '0;
    bus.ready_out    = 1'b1;

    // Single source on input 1: HEAD, BODY, BODY, TAIL.
    do_reset();
    push_pkt(1, 1, 2, 1'b1);
    expect_pkt(1, 1, 2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t1_ready", 64'(last_rdy), 64'(3'b010));
      check("t1_valid", 64'(bus.valid_out), 64'd1);
      check("t1_data", bus.data_out, exp_q[k]);
      check("t1_grant", 64'(bus.grant), (k < 3) ? 64'(3'b010) : 64'd0);
    end
    cycle();
    check("t1_drain", 64'(bus.valid_out), 64'd0);
    check("t1_err", 64'(bus.pkt_err), 64'd0);
    check_out("t1_stream");

    // Contention: all inputs valid from reset, input 0 has a second packet queued.
    push_pkt(0, 2, 1, 1'b1);
    push_pkt(0, 3, 1, 1'b1);
    push_pkt(1, 4, 1, 1'b1);
    push_pkt(2, 5, 1, 1'b1);
    expect_pkt(0, 2, 1, 1'b1);
    expect_pkt(1, 4, 1, 1'b1);
    expect_pkt(2, 5, 1, 1'b1);
    expect_pkt(0, 3, 1, 1'b1);
    do_reset();
    for (int k = 0; k < 13; k++) cycle();
    check("t2_idle_valid", 64'(bus.valid_out), 64'd0);
    check_out("t2_order");

    // Backpressure: 5 stalled cycles mid-packet on input 1.
    push_pkt(1, 6, 3, 1'b1);
    expect_pkt(1, 6, 3, 1'b1);
    cycle();
    cycle();
    bus.ready_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t3_ready", 64'(last_rdy), 64'd0);
      check("t3_hold", bus.data_out, exp_q[1]);
      check("t3_valid", 64'(bus.valid_out), 64'd1);
    end
    bus.ready_out = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    check_out("t3_stream");

    // Interleave guard: input 2 HEAD arrives while input 0 owns the output.
    t4_rdy = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100};
    push_pkt(0, 7, 2, 1'b1);
    expect_pkt(0, 7, 2, 1'b1);
    expect_pkt(2, 8, 0, 1'b1);
    cycle();
    check("t4_grant0", 64'(bus.grant), 64'(3'b001));
    push_pkt(2, 8, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t4_ready", 64'(last_rdy), 64'(t4_rdy[k]));
    end
    cycle();
    check_out("t4_stream");

    // Overlength: HEAD plus 16 BODY flits on input 0.
    push_pkt(0, 9, 16, 1'b0);
    expect_pkt(0, 9, 15, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      cycle();
      if (k == 15) begin
        check("t5_grant_15", 64'(bus.grant), 64'(3'b001));
        check("t5_err_15", 64'(bus.pkt_err), 64'd0);
      end
      if (k == 16) begin
        check("t5_grant_16", 64'(bus.grant), 64'd0);
        check("t5_err_16", 64'(bus.pkt_err), 64'd1);
      end
    end
    cycle();
    check("t5_discard_ready", 64'(last_rdy), 64'(3'b001));
    check("t5_discard_noload", 64'(bus.valid_out), 64'd0);
    check("t5_discard_popped", 64'(src_q[0].size()), 64'd0);
    check_out("t5_stream");

    // Asynchronous reset during the second flit of a packet.
    push_pkt(0, 10, 2, 1'b1);
    cycle();
    cycle();
    check("t6_pre_valid", 64'(bus.valid_out), 64'd1);
    check("t6_pre_grant", 64'(bus.grant), 64'(3'b001));
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(bus.valid_out), 64'd0);
    check("t6_async_grant", 64'(bus.grant), 64'd0);
    check("t6_async_err", 64'(bus.pkt_err), 64'd0);
    check("t6_async_ready", 64'(bus.ready_in_bus), 64'd0);
    check("t6_async_data", bus.data_out, 64'd0);
    @(posedge clk);
    #1;
    src_q[0].delete();
    out_q.delete();
    rst = 1'b0;
    push_pkt(2, 11, 0, 1'b1);
    expect_pkt(2, 11, 0, 1'b1);
    cycle();
    check("t6_ready", 64'(last_rdy), 64'(3'b100));
    check("t6_grant", 64'(bus.grant), 64'(3'b100));
    check("t6_data", bus.data_out, exp_q[0]);
    cycle();
    check("t6_release", 64'(bus.grant), 64'd0);
    cycle();
    check_out("t6_stream");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
